// File: rtl/dec_rc_pkg.sv
// Shared types for the decoder rate-control block sequencer.
// Optional stall counter in the top is enabled by DEC_RC_SEQ_STALL_CNT_EN.
package dec_rc_pkg;

    localparam int NUM_SSM = 4;
    localparam int BITS_W  = 8;
    localparam int BLK_PIX = 16;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        UPDATE,
        QP_OUT,
        DONE
    } seqState_t;

endpackage

// File: rtl/dec_ssm_slot.sv
// One substream bit-count slot: holds a single count until the block
// update clears it; refuses new data while full.
module dec_ssm_slot
    import dec_rc_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              clr,
    input  logic              vld,
    input  logic [BITS_W-1:0] din,
    output logic              rdy,
    output logic              full,
    output logic [BITS_W-1:0] dout
);

    assign rdy = en & ~full;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full <= 1'b0;
            dout <= '0;
        end else if (clr) begin
            full <= 1'b0;
        end else if (vld & rdy) begin
            full <= 1'b1;
            dout <= din;
        end
    end

endmodule

// File: rtl/dec_rc_blk_sequencer.sv
// Per-block RC sequencer: gathers substream counts, strobes RC, hands QP on.
// Define DEC_RC_SEQ_STALL_CNT_EN to add the stall_cnt output.
module dec_rc_blk_sequencer
    import dec_rc_pkg::*;
(
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      slice_start,
    input  logic [15:0]               r_sliceWidth,
    input  logic [15:0]               r_sliceHeight,
    input  logic [NUM_SSM-1:0]        ssm_vld,
    input  logic [NUM_SSM*BITS_W-1:0] ssm_bits,
    output logic [NUM_SSM-1:0]        ssm_rdy,
    output logic                      rc_start,
    output logic                      rc_isFls,
    output logic [NUM_SSM*BITS_W-1:0] rc_bits,
    input  logic [7:0]                rc_qp,
    output logic                      qp_vld,
    output logic [7:0]                qp_out,
    input  logic                      qp_rdy,
    output logic [7:0]                blk_x,
    output logic [14:0]               blk_y,
    output logic                      slice_busy,
    output logic                      slice_done,
`ifdef DEC_RC_SEQ_STALL_CNT_EN
    output logic [15:0]               stall_cnt,
`endif
    output logic                      slice_err
);

    seqState_t state, nextState;

    logic [7:0]  cols, colsIn;
    logic [14:0] rows, rowsIn;
    logic        dimOk, startOk, allFull;
    logic        lastCol, lastRow, accept;
    logic        collect, clrSlots;
    logic [NUM_SSM-1:0]        slotFull;
    logic [NUM_SSM*BITS_W-1:0] slotData;
    logic        unusedBits;

    assign colsIn     = r_sliceWidth[10:3];
    assign rowsIn     = r_sliceHeight[15:1];
    assign unusedBits = ^{r_sliceWidth[15:11], r_sliceWidth[2:0],
                          r_sliceHeight[0]};
    assign dimOk      = (colsIn != 8'd0) && (rowsIn != 15'd0);
    assign startOk    = (state == IDLE) && slice_start && dimOk;
    assign allFull    = &slotFull;
    assign lastCol    = (blk_x == cols - 8'd1);
    assign lastRow    = (blk_y == rows - 15'd1);
    assign accept     = (state == QP_OUT) && qp_rdy;

    for (genvar i = 0; i < NUM_SSM; i++) begin : gSlot
        dec_ssm_slot uSlot (
            .clk  (clk),
            .rstn (rstn),
            .en   (collect),
            .clr  (clrSlots),
            .vld  (ssm_vld[i]),
            .din  (ssm_bits[i*BITS_W +: BITS_W]),
            .rdy  (ssm_rdy[i]),
            .full (slotFull[i]),
            .dout (slotData[i*BITS_W +: BITS_W])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (startOk) nextState = COLLECT;
            COLLECT: if (allFull) nextState = UPDATE;
            UPDATE:  nextState = QP_OUT;
            QP_OUT:  if (qp_rdy)
                         nextState = (lastCol && lastRow) ? DONE : COLLECT;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        collect    = 1'b0;
        clrSlots   = 1'b0;
        rc_start   = 1'b0;
        qp_vld     = 1'b0;
        slice_busy = 1'b0;
        slice_done = 1'b0;
        unique case (state)
            IDLE:    ;
            COLLECT: begin
                collect    = 1'b1;
                slice_busy = 1'b1;
            end
            UPDATE: begin
                rc_start   = 1'b1;
                clrSlots   = 1'b1;
                slice_busy = 1'b1;
            end
            QP_OUT: begin
                qp_vld     = 1'b1;
                slice_busy = 1'b1;
            end
            DONE:    slice_done = 1'b1;
            default: ;
        endcase
    end

    // RC inputs load on entry to UPDATE so they are already valid with rc_start
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cols      <= '0;
            rows      <= '0;
            blk_x     <= '0;
            blk_y     <= '0;
            slice_err <= 1'b0;
            rc_bits   <= '0;
            rc_isFls  <= 1'b0;
            qp_out    <= '0;
        end else begin
            if (state == IDLE && slice_start) begin
                if (dimOk) begin
                    slice_err <= 1'b0;
                    cols      <= colsIn;
                    rows      <= rowsIn;
                    blk_x     <= '0;
                    blk_y     <= '0;
                end else begin
                    slice_err <= 1'b1;
                end
            end
            if (state == COLLECT && allFull) begin
                rc_bits  <= slotData;
                rc_isFls <= (blk_y == 15'd0);
            end
            if (state == UPDATE) qp_out <= rc_qp;
            if (accept) begin
                if (lastCol) begin
                    blk_x <= '0;
                    blk_y <= blk_y + 15'd1;
                end else begin
                    blk_x <= blk_x + 8'd1;
                end
            end
        end
    end

`ifdef DEC_RC_SEQ_STALL_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            stall_cnt <= '0;
        else if (startOk)
            stall_cnt <= '0;
        else if (state == QP_OUT && !qp_rdy && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_dec_rc_blk_sequencer.sv
// Randomized bench for dec_rc_blk_sequencer against a cycle-level
// transaction model of block collection, RC update and QP hand-off.
module tb_dec_rc_blk_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        slice_start;
    logic [15:0] r_sliceWidth, r_sliceHeight;
    logic [3:0]  ssm_vld;
    logic [31:0] ssm_bits;
    logic [3:0]  ssm_rdy;
    logic        rc_start, rc_isFls;
    logic [31:0] rc_bits;
    logic [7:0]  rc_qp;
    logic        qp_vld;
    logic [7:0]  qp_out;
    logic        qp_rdy;
    logic [7:0]  blk_x;
    logic [14:0] blk_y;
    logic        slice_busy, slice_done, slice_err;
`ifdef DEC_RC_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] expBits;
    logic        expFls;
    logic [7:0]  expQp;
    logic        expErr;

    always #5 clk = ~clk;

    dec_rc_blk_sequencer dut (
`ifdef DEC_RC_SEQ_STALL_CNT_EN
        .stall_cnt     (stall_cnt),
`endif
        .clk           (clk),
        .rstn          (rstn),
        .slice_start   (slice_start),
        .r_sliceWidth  (r_sliceWidth),
        .r_sliceHeight (r_sliceHeight),
        .ssm_vld       (ssm_vld),
        .ssm_bits      (ssm_bits),
        .ssm_rdy       (ssm_rdy),
        .rc_start      (rc_start),
        .rc_isFls      (rc_isFls),
        .rc_bits       (rc_bits),
        .rc_qp         (rc_qp),
        .qp_vld        (qp_vld),
        .qp_out        (qp_out),
        .qp_rdy        (qp_rdy),
        .blk_x         (blk_x),
        .blk_y         (blk_y),
        .slice_busy    (slice_busy),
        .slice_done    (slice_done),
        .slice_err     (slice_err)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chkZero(input string tag);
        chk({tag, "Busy"}, slice_busy, 0);
        chk({tag, "Done"}, slice_done, 0);
        chk({tag, "Start"}, rc_start, 0);
        chk({tag, "QpVld"}, qp_vld, 0);
        chk({tag, "QpOut"}, qp_out, 0);
        chk({tag, "Bits"}, rc_bits, 0);
        chk({tag, "Fls"}, rc_isFls, 0);
        chk({tag, "BlkX"}, blk_x, 0);
        chk({tag, "BlkY"}, blk_y, 0);
        chk({tag, "Rdy"}, ssm_rdy, 0);
        chk({tag, "Err"}, slice_err, 0);
    endtask

    // abortBlk >= 0 pulls rstn while that block waits in QP hand-off
    task automatic runSlice(input int cols, input int rows,
                            input int vldPct, input int rdyPct,
                            input bit stagger, input bit holdRdy,
                            input int abortBlk);
        int n, acc, age, qpAge, cyc;
        logic [31:0] blk[];
        int sent[4];
        bit pres[4];
        bit filled[4];
        bit collecting, updNow, qpWait, doneNow, finished;
        logic [3:0] expRdy;
        n = cols * rows;
        blk = new[n];
        foreach (blk[b]) blk[b] = $urandom;
        for (int i = 0; i < 4; i++) begin
            sent[i] = 0;
            pres[i] = 0;
            filled[i] = 0;
        end
        @(negedge clk);
        chk("preBusy", slice_busy, 0);
        chk("preErr", slice_err, expErr);
        r_sliceWidth  = 16'(cols * 8);
        r_sliceHeight = 16'(rows * 2);
        slice_start   = 1'b1;
        expErr     = 1'b0;
        collecting = 1;
        updNow     = 0;
        qpWait     = 0;
        doneNow    = 0;
        finished   = 0;
        acc   = 0;
        age   = 0;
        qpAge = 0;
        cyc   = 0;
        while (!finished && cyc < 4000) begin
            @(negedge clk);
            slice_start = 1'b0;
            cyc++;
            if (abortBlk >= 0 && qpWait && acc == abortBlk) begin
                rstn = 1'b0;
                ssm_vld = '0;
                qp_rdy = 1'b0;
                #1;
                chkZero("rst");
                expBits = '0;
                expFls  = 1'b0;
                expQp   = '0;
                expErr  = 1'b0;
                @(negedge clk);
                rstn = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("rstNoDone", slice_done, 0);
                    chk("rstNoBusy", slice_busy, 0);
                end
                return;
            end
            for (int i = 0; i < 4; i++)
                expRdy[i] = collecting && !filled[i];
            if (updNow) begin
                expBits = blk[acc];
                expFls  = (acc < cols);
            end
            chk("busy", slice_busy, collecting | updNow | qpWait);
            chk("done", slice_done, doneNow);
            chk("err", slice_err, expErr);
            chk("rcStart", rc_start, updNow);
            chk("qpVld", qp_vld, qpWait);
            chk("blkX", blk_x, acc % cols);
            chk("blkY", blk_y, acc / cols);
            chk("ssmRdy", ssm_rdy, expRdy);
            chk("rcBits", rc_bits, expBits);
            chk("rcFls", rc_isFls, expFls);
            chk("qpOut", qp_out, expQp);

            rc_qp = 8'($urandom);
            for (int i = 0; i < 4; i++) begin
                if (!pres[i] && sent[i] < n) begin
                    if (stagger)
                        pres[i] = collecting && (age >= (3 - i) * 3);
                    else
                        pres[i] = ($urandom_range(99) < vldPct);
                end
                ssm_vld[i] = pres[i];
                ssm_bits[i*8 +: 8] = pres[i] ? blk[sent[i]][i*8 +: 8]
                                             : 8'($urandom);
            end
            if (holdRdy && qpAge < 5)
                qp_rdy = 1'b0;
            else
                qp_rdy = ($urandom_range(99) < rdyPct);

            if (doneNow) begin
                doneNow  = 0;
                finished = 1;
            end else if (updNow) begin
                updNow = 0;
                qpWait = 1;
                qpAge  = 0;
                expQp  = rc_qp;
                for (int i = 0; i < 4; i++) filled[i] = 0;
            end else if (qpWait) begin
                qpAge++;
                if (qp_rdy) begin
                    qpWait = 0;
                    acc++;
                    if (acc == n) doneNow = 1;
                    else begin
                        collecting = 1;
                        age = 0;
                    end
                end
            end else if (collecting) begin
                if (filled[0] && filled[1] && filled[2] && filled[3]) begin
                    collecting = 0;
                    updNow = 1;
                end else begin
                    for (int i = 0; i < 4; i++)
                        if (ssm_vld[i] && !filled[i]) begin
                            filled[i] = 1;
                            sent[i]++;
                            pres[i] = 0;
                        end
                    age++;
                end
            end
        end
        chk("timeout", finished, 1);
        ssm_vld = '0;
        qp_rdy  = 1'b0;
        @(negedge clk);
        chk("idleBusy", slice_busy, 0);
        chk("idleDone", slice_done, 0);
        chk("idleRdy", ssm_rdy, 0);
    endtask

    initial begin
        rstn = 1'b0;
        slice_start = 1'b0;
        r_sliceWidth = '0;
        r_sliceHeight = '0;
        ssm_vld = '0;
        ssm_bits = '0;
        rc_qp = '0;
        qp_rdy = 1'b0;
        expBits = '0;
        expFls = 1'b0;
        expQp = '0;
        expErr = 1'b0;
        repeat (3) @(negedge clk);
        chkZero("reset");
        rstn = 1'b1;

        runSlice(2, 2, 100, 100, 0, 0, -1);
        runSlice(1, 2, 0, 100, 1, 0, -1);
        runSlice(2, 1, 100, 100, 0, 1, -1);
        runSlice(3, 2, 60, 50, 0, 0, -1);

        @(negedge clk);
        r_sliceWidth  = 16'd4;
        r_sliceHeight = 16'd4;
        slice_start   = 1'b1;
        @(negedge clk);
        slice_start = 1'b0;
        chk("badErr", slice_err, 1);
        chk("badBusy", slice_busy, 0);
        chk("badRdy", ssm_rdy, 0);
        @(negedge clk);
        chk("badSticky", slice_err, 1);
        expErr = 1'b1;
        runSlice(1, 1, 100, 100, 0, 0, -1);

        runSlice(2, 2, 100, 100, 0, 0, 1);
        runSlice(2, 2, 100, 100, 0, 0, -1);

        for (int k = 0; k < 4; k++)
            runSlice($urandom_range(4, 1), $urandom_range(3, 1),
                     $urandom_range(90, 30), $urandom_range(90, 30),
                     0, k[0], -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
